// File: rtl/eq_pkg.sv
// Shared constants, sizing helper and FSM encoding for the equalizer
// coefficient store.
package eq_pkg;

  localparam int NR_CHANNELS      = 4;
  localparam int NR_EQ_BANDS      = 8;
  localparam int NR_EQ_BAND_COEFF = 5;
  localparam int EQ_COEFF_WIDTH   = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int NR_EQ_COEFF = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF;
  localparam int ADDR_W      = clog2(NR_EQ_COEFF);

  // Highest legal word address; used instead of NR_EQ_COEFF so the
  // comparison stays within ADDR_W bits even for power-of-two sizes.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NR_EQ_COEFF - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PENDING,
    ST_SWAP,
    ST_COPY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/eq_coeff_ctrl_if.sv
// Host write/commit and equalizer read signals of eq_coeff_ctrl, with the
// driving side (master) and the coefficient store side (slave).
interface eq_coeff_ctrl_if;
  import eq_pkg::*;

  logic [EQ_COEFF_WIDTH-1:0] h_wr_d;
  logic [ADDR_W-1:0]         h_wr_addr;
  logic                      h_wr_dv;
  logic                      h_wr_dr;
  logic                      h_commit;
  logic                      commit_done;
  logic                      eq_idle;
  logic [ADDR_W-1:0]         eq_coeff_addr;
  logic [EQ_COEFF_WIDTH-1:0] eq_coeff;
  logic                      bank;
  logic                      busy;

  modport master (
    output h_wr_d, h_wr_addr, h_wr_dv, h_commit, eq_idle, eq_coeff_addr,
    input  h_wr_dr, commit_done, eq_coeff, bank, busy
  );

  modport slave (
    input  h_wr_d, h_wr_addr, h_wr_dv, h_commit, eq_idle, eq_coeff_addr,
    output h_wr_dr, commit_done, eq_coeff, bank, busy
  );

endinterface

// File: rtl/eq_coeff_ram.sv
// Two-bank coefficient RAM: one write port, one registered read port.
// Address MSB selects the bank; range checking is left to the parent.
module eq_coeff_ram
  import eq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W:0]           waddr,
  input  logic [EQ_COEFF_WIDTH-1:0] wdata,
  input  logic [ADDR_W:0]           raddr,
  output logic [EQ_COEFF_WIDTH-1:0] rdata
);

  logic [EQ_COEFF_WIDTH-1:0] mem [2][NR_EQ_COEFF];

  // NOTE: the array itself has no reset so it maps onto block RAM; only the
  // read-data register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[ADDR_W]][waddr[ADDR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr[ADDR_W]][raddr[ADDR_W-1:0]];
  end

endmodule

// File: rtl/eq_coeff_ctrl.sv
// Double-buffered equalizer coefficient store with commit sequencer.
// Define EQ_COEFF_COPY_EN to refresh the shadow bank from the active bank after each swap.
module eq_coeff_ctrl
  import eq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  eq_coeff_ctrl_if.slave bus
);

  state_e state_q, state_d;
  logic   bank_q;
  logic   wr_rdy, busy, done;
  logic   host_wr, eq_oob, eq_oob_q;
  logic   copy_rd, cpy_vld, cpy_last;
  logic [ADDR_W-1:0]         cpy_cnt, cpy_waddr, eq_rd_addr;
  logic [ADDR_W:0]           ram_waddr, ram_raddr;
  logic                      ram_we;
  logic [EQ_COEFF_WIDTH-1:0] ram_wdata, ram_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    wr_rdy  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy   = 1'b0;
        wr_rdy = !rst;
        if (bus.h_commit) state_d = ST_PENDING;
      end
      ST_PENDING: if (bus.eq_idle) state_d = ST_SWAP;
`ifdef EQ_COEFF_COPY_EN
      ST_SWAP: state_d = ST_COPY;
      ST_COPY: if (cpy_last) state_d = ST_DONE;
`else
      ST_SWAP: state_d = ST_DONE;
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     bank_q <= 1'b0;
    else if (state_q == ST_SWAP) bank_q <= ~bank_q;
  end

`ifdef EQ_COEFF_COPY_EN
  logic cpy_issued_q, cpy_vld_q;
  logic [ADDR_W-1:0] cpy_cnt_q, cpy_waddr_q;

  // The equalizer owns the read port unless it is idle.
  assign copy_rd = (state_q == ST_COPY) && bus.eq_idle && !cpy_issued_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpy_cnt_q    <= '0;
      cpy_waddr_q  <= '0;
      cpy_issued_q <= 1'b0;
      cpy_vld_q    <= 1'b0;
    end else begin
      cpy_vld_q <= copy_rd;
      if (state_q == ST_SWAP) begin
        cpy_cnt_q    <= '0;
        cpy_issued_q <= 1'b0;
      end else if (copy_rd) begin
        cpy_waddr_q <= cpy_cnt_q;
        if (cpy_cnt_q == LAST_ADDR) cpy_issued_q <= 1'b1;
        else                        cpy_cnt_q    <= cpy_cnt_q + ADDR_W'(1);
      end
    end
  end

  assign cpy_cnt   = cpy_cnt_q;
  assign cpy_waddr = cpy_waddr_q;
  assign cpy_vld   = cpy_vld_q;
  assign cpy_last  = cpy_vld_q && (cpy_waddr_q == LAST_ADDR);
`else
  assign copy_rd   = 1'b0;
  assign cpy_cnt   = '0;
  assign cpy_waddr = '0;
  assign cpy_vld   = 1'b0;
  assign cpy_last  = 1'b0;
`endif

  assign host_wr    = bus.h_wr_dv && wr_rdy && (bus.h_wr_addr <= LAST_ADDR);
  assign eq_oob     = bus.eq_coeff_addr > LAST_ADDR;
  assign eq_rd_addr = eq_oob ? '0 : bus.eq_coeff_addr;

  // Copy write data is the word read from the active bank on the previous cycle.
  assign ram_we    = host_wr || cpy_vld;
  assign ram_waddr = cpy_vld ? {~bank_q, cpy_waddr} : {~bank_q, bus.h_wr_addr};
  assign ram_wdata = cpy_vld ? ram_rdata : bus.h_wr_d;
  assign ram_raddr = copy_rd ? {bank_q, cpy_cnt} : {bank_q, eq_rd_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) eq_oob_q <= 1'b0;
    else     eq_oob_q <= eq_oob && !copy_rd;
  end

  eq_coeff_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.h_wr_dr     = wr_rdy;
  assign bus.commit_done = done;
  assign bus.busy        = busy;
  assign bus.bank        = bank_q;
  assign bus.eq_coeff    = eq_oob_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_eq_coeff_ctrl.sv
// Randomized scoreboard bench for eq_coeff_ctrl against a two-bank array model;
// expectations follow EQ_COEFF_COPY_EN when it is defined.
`timescale 1ns/1ps
module tb_eq_coeff_ctrl;
  import eq_pkg::*;

  localparam int N = NR_EQ_COEFF;
`ifdef EQ_COEFF_COPY_EN
  localparam int COPY_CYC = N + 1;
`else
  localparam int COPY_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  eq_coeff_ctrl_if bus ();

  eq_coeff_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two banks of words plus the active-bank index.
  logic [31:0] mdl [2][N];
  int          mbank = 0;

  logic [31:0] exp_q [$];
  logic        done_q [$];
  logic        rd_req   = 1'b0;
  logic        rd_req_d = 1'b0;

  always @(posedge clk) rd_req_d <= rd_req;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each equalizer read and each commit_done pulse.
  initial forever begin
    @(negedge clk);
    if (rd_req_d) begin
      if (exp_q.size() == 0) check("rd_queue_depth", exp_q.size(), 1);
      else                   check("eq_coeff", bus.eq_coeff, exp_q.pop_front());
    end
    if (bus.commit_done) begin
      if (done_q.size() == 0) check("commit_done_unexpected", bus.commit_done, 0);
      else                    check("bank_at_done", bus.bank, done_q.pop_front());
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] active(input int a);
    return (a < N) ? mdl[mbank][a] : 32'h0;
  endfunction

  function automatic void swap_model();
    mbank = 1 - mbank;
  endfunction

  function automatic void copy_model();
    for (int i = 0; i < N; i++) mdl[1-mbank][i] = mdl[mbank][i];
  endfunction

  task automatic host_write(input int a, input logic [31:0] d);
    bus.h_wr_addr = a[ADDR_W-1:0];
    bus.h_wr_d    = d;
    bus.h_wr_dv   = 1'b1;
    check("h_wr_dr", bus.h_wr_dr, 1);
    step();
    bus.h_wr_dv = 1'b0;
    if (a < N) mdl[1-mbank][a] = d;
  endtask

  task automatic eq_read(input int a);
    bus.eq_coeff_addr = a[ADDR_W-1:0];
    rd_req = 1'b1;
    exp_q.push_back(active(a));
    step();
    rd_req = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.commit_done && lat < 2000) begin
      step();
      lat++;
    end
    check("commit_done_seen", bus.commit_done, 1);
  endtask

  task automatic commit_idle(input bit with_wr = 1'b0, input int a = 0, input logic [31:0] d = 32'h0);
    int lat;
    bus.eq_idle  = 1'b1;
    bus.h_commit = 1'b1;
    if (with_wr) begin
      bus.h_wr_addr = a[ADDR_W-1:0];
      bus.h_wr_d    = d;
      bus.h_wr_dv   = 1'b1;
    end
    check("h_wr_dr_at_commit", bus.h_wr_dr, 1);
    done_q.push_back(mbank == 0);
    step();
    bus.h_commit = 1'b0;
    bus.h_wr_dv  = 1'b0;
    if (with_wr && a < N) mdl[1-mbank][a] = d;
    wait_done(lat);
    check("commit_latency", lat, 2 + COPY_CYC);
    swap_model();
`ifdef EQ_COEFF_COPY_EN
    copy_model();
`endif
    step();
    check("busy_after_done", bus.busy, 0);
  endtask

  task automatic read_all();
    bus.eq_idle = 1'b0;
    for (int i = 0; i < N; i++) eq_read(i);
  endtask

  initial begin
    int lat;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mdl[b][i] = 32'h0;
    bus.h_wr_d = '0; bus.h_wr_addr = '0; bus.h_wr_dv = 1'b0; bus.h_commit = 1'b0;
    bus.eq_idle = 1'b1; bus.eq_coeff_addr = '0;

    // Reset values
    #1 rst = 1'b1;
    step(); step();
    check("rst_h_wr_dr", bus.h_wr_dr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_bank", bus.bank, 0);
    check("rst_commit_done", bus.commit_done, 0);
    check("rst_eq_coeff", bus.eq_coeff, 0);
    rst = 1'b0;
    step();
    check("h_wr_dr_after_rst", bus.h_wr_dr, 1);
    bus.eq_idle = 1'b0;
    eq_read(5);

    // Basic write, commit and read back from the new active bank
    host_write(7, 32'h1234_5678);
    commit_idle();
    check("bank_after_commit", bus.bank, mbank);
    bus.eq_idle = 1'b0;
    eq_read(7);
    eq_read(200);

    // Commit held off by a busy equalizer
    bus.eq_idle  = 1'b0;
    bus.h_commit = 1'b1;
    done_q.push_back(mbank == 0);
    step();
    bus.h_commit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 0) begin
        check("pending_bank", bus.bank, mbank);
        check("pending_h_wr_dr", bus.h_wr_dr, 0);
        check("pending_busy", bus.busy, 1);
      end
      if (i == 20) begin
        bus.h_wr_dv   = 1'b1;
        bus.h_wr_addr = 8'd7;
        bus.h_wr_d    = 32'hDEAD_BEEF;
      end
      bus.h_commit = (i == 30);
      eq_read($urandom_range(0, N - 1));
      bus.h_wr_dv  = 1'b0;
      bus.h_commit = 1'b0;
    end
    bus.eq_idle = 1'b1;
    step();
    check("swap_cycle_bank", bus.bank, mbank);
    check("swap_cycle_busy", bus.busy, 1);
    step();
    check("bank_after_swap", bus.bank, 1 - mbank);
    wait_done(lat);
    swap_model();
`ifdef EQ_COEFF_COPY_EN
    copy_model();
`endif
    step();

    // Partial update: only the rewritten word changes with copy-back
    host_write(3, 32'hA);
    commit_idle();
    host_write(4, 32'hB);
    commit_idle();
    bus.eq_idle = 1'b0;
    eq_read(3);
    eq_read(4);

    // Write and commit in the same cycle
    commit_idle(1'b1, 9, 32'h0BAD_F00D);
    bus.eq_idle = 1'b0;
    eq_read(9);

`ifdef EQ_COEFF_COPY_EN
    // Equalizer traffic interleaved with the copy
    for (int i = 0; i < 6; i++) host_write($urandom_range(0, N - 1), $urandom);
    bus.eq_idle  = 1'b1;
    bus.h_commit = 1'b1;
    done_q.push_back(mbank == 0);
    step();
    bus.h_commit = 1'b0;
    step(); step();
    swap_model();
    check("copy_bank", bus.bank, mbank);
    begin
      int cyc = 0;
      while (!bus.commit_done && cyc < 2000) begin
        bus.eq_idle = ((cyc / 3) % 2) == 1;
        if (!bus.eq_idle) eq_read($urandom_range(0, N - 1));
        else              step();
        cyc++;
      end
    end
    check("toggle_commit_done", bus.commit_done, 1);
    copy_model();
    step();
    read_all();
    commit_idle();
    read_all();
`endif

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) host_write($urandom_range(0, N + 40), $urandom);
      else if (r < 85) begin
        bus.eq_idle = 1'($urandom_range(0, 1));
        eq_read($urandom_range(0, N + 20));
      end else if (r < 93) commit_idle(1'($urandom_range(0, 1)), $urandom_range(0, N + 40), $urandom);
      else step();
    end

    // Reset mid-operation; the prior commit leaves both banks equal under copy-back
    commit_idle();
`ifdef EQ_COEFF_COPY_EN
    bus.eq_idle = 1'b1;
    bus.h_commit = 1'b1;
    step();
    bus.h_commit = 1'b0;
    for (int i = 0; i < 22; i++) step();
    check("mid_copy_busy", bus.busy, 1);
`else
    bus.eq_idle = 1'b0;
    bus.h_commit = 1'b1;
    step();
    bus.h_commit = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_pending_busy", bus.busy, 1);
`endif
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_bank", bus.bank, 0);
    check("abort_commit_done", bus.commit_done, 0);
    check("abort_h_wr_dr", bus.h_wr_dr, 0);
    mbank = 0;
    step(); step();
    rst = 1'b0;
    step();
    check("h_wr_dr_after_abort", bus.h_wr_dr, 1);
    host_write(200, 32'hCAFE_0001);
    read_all();
    eq_read(200);
    commit_idle();
    read_all();

    step(); step();
    check("reads_outstanding", exp_q.size(), 0);
    check("commits_outstanding", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
